// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: FIFO-buffered operand feeder that runs one dot product on a downstream 8x8 MAC.
// Define MAC_SEQ_OVF_EN to add result_ovf, flagging sums that left the signed 16-bit range.
module mac_dot_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             mac_clr,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  input  logic [15:0]      mac_f,
  output logic             result_valid,
  output logic [15:0]      result
`ifdef MAC_SEQ_OVF_EN
  ,
  output logic             result_ovf
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, FEED = 2'd2, DRAIN = 2'd3;
  logic [1:0] state;
  logic [7:0] fa [DEPTH];
  logic [7:0] fb [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [LEN_W-1:0] rem;
  logic [1:0] drain;
  logic push, pop;
  assign in_ready = cnt != FULL;
  assign push = in_valid && in_ready;
  assign pop = state == FEED && cnt != '0;
  assign busy = state != IDLE;
  assign mac_clr = !reset || state == CLEAR;
  // Zeros outside a real pop keep stall cycles from adding anything to the MAC.
  assign mac_a = (reset && pop) ? fa[rp] : 8'd0;
  assign mac_b = (reset && pop) ? fb[rp] : 8'd0;
  always_ff @(posedge clk)
    if (push) begin
      fa[wp] <= in_a;
      fb[wp] <= in_b;
    end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      rem <= '0;
      drain <= '0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
      case (state)
        IDLE:
          if (start) begin
            rem <= len;
            state <= CLEAR;
          end
        CLEAR: begin
          state <= rem != '0 ? FEED : DRAIN;
          drain <= 2'd2;
        end
        FEED:
          if (pop) begin
            rem <= rem - 1'b1;
            if (rem == LEN_W'(1)) begin
              state <= DRAIN;
              drain <= 2'd2;
            end
          end
        default: begin
          drain <= drain - 2'd1;
          if (drain == 2'd0) begin
            result <= mac_f;
            result_valid <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
`ifdef MAC_SEQ_OVF_EN
  localparam int SW = 16 + LEN_W;
  logic signed [15:0] prod;
  logic [SW-1:0] sh;
  logic ovf;
  assign prod = $signed(mac_a) * $signed(mac_b);
  // Out of 16-bit range exactly when the bits above the sign bit disagree.
  assign ovf = !(&sh[SW-1:15] || ~|sh[SW-1:15]);
  always_ff @(posedge clk)
    if (!reset) begin
      sh <= '0;
      result_ovf <= 1'b0;
    end else begin
      if (state == CLEAR) sh <= '0;
      else if (pop) sh <= sh + {{LEN_W{prod[15]}}, prod};
      if (state == DRAIN && drain == 2'd0) result_ovf <= ovf;
    end
`endif
endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Control stage directly upstream of the 8x8 signed MAC (registered operands, registered product, 16-bit accumulator, active-high sync clear).
- Buffers incoming signed operand pairs in a small FIFO and clears the MAC at the start of each dot product.
- Streams exactly `len` pairs into the MAC, waits out the MAC pipeline, then captures the accumulated result with a one-cycle valid pulse.

Parameters:
- DEPTH, 4: operand FIFO entries; power of two, ≥2.
- LEN_W, 8: width of the `len` field (max 2^LEN_W−1 pairs per dot product).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; high iff occupancy < DEPTH.
- in_a  in  8  signed operand a.
- in_b  in  8  signed operand b.
- start  in  1  begin dot product; sampled only in IDLE.
- len  in  LEN_W  number of pairs; latched on accepted start.
- busy  out  1  high in any state other than IDLE.
- mac_clr  out  1  to MAC reset (active-high).
- mac_a  out  8  to MAC a.
- mac_b  out  8  to MAC b.
- mac_f  in  16  MAC accumulator output f.
- result_valid  out  1  one-cycle pulse.
- result  out  16  captured signed sum; holds until the next capture.

Behaviour:
- Reset (reset=0 at edge):
  - State → IDLE; FIFO emptied; busy=0; result_valid=0; result=0.
  - mac_clr is driven combinationally high whenever reset=0, so the MAC clears on the same edge.
  - mac_a=mac_b=0.
  - Reset mid-operation abandons the dot product; no result_valid.
- FIFO:
  - Push when in_valid && in_ready. Pop only in FEED when non-empty.
  - Push and pop in the same cycle are both honoured.
  - in_ready is based on registered occupancy only; no full-pass-through.
  - Pointers wrap modulo DEPTH.
  - Pairs may be pre-loaded in IDLE.
- mac_a/mac_b:
  - Equal the FIFO head in a FEED cycle with a non-empty FIFO.
  - Otherwise 0, so zero products add nothing.
- States:
  - IDLE: on start=1, latch len into remaining counter, go to CLEAR. start is ignored while busy.
  - CLEAR: exactly one cycle with mac_clr=1. Next state is FEED if len≠0, else DRAIN.
  - FEED: each cycle with a non-empty FIFO pops one pair and decrements remaining.
    - An empty FIFO stalls the sequencer with zeros driven; there is no timeout.
    - The edge that pops the last pair moves to DRAIN with drain counter = 2.
  - DRAIN: drain counter decrements each edge. At the edge where the counter is 0:
    - result ← mac_f
    - result_valid ← 1 for one cycle
    - state → IDLE.
- Latency:
  - The last pair is popped at edge k; result_valid is high after edge k+3.
  - For len=0: CLEAR edge c; result=0 valid after edge c+3.
- Arithmetic: 16-bit two's-complement wrap, exactly as the MAC produces it; the sequencer does not alter the value.

Optional Feature:
- Macro: MAC_SEQ_OVF_EN.
- Defined:
  - Adds output `result_ovf` (1 bit).
  - A shadow accumulator of (16+LEN_W) bits sums the sign-extended products of the popped pairs; it is cleared in CLEAR.
  - At capture, result_ovf ← 1 iff the shadow value is outside [−32768, 32767]. It updates together with result.
  - result_ovf resets to 0.
- Undefined: no port, no shadow logic; behaviour otherwise identical.

Test Plan:
- Basic sum: reset; push (1,2),(−3,4),(2,8); start len=3 → mac_clr pulses 1 cycle; result=6; result_valid high exactly 1 cycle, 3 edges after the last pop.
- Zero length: start len=0 → no pops, result=0, result_valid pulses; FIFO contents untouched.
- Full FIFO: DEPTH=4, hold in_valid for 5 pairs in IDLE → in_ready low after 4 accepts; 5th accepted only after FEED pops; start len=5 of (1,1) → result=5.
- Starvation: start len=3 with 1 pair queued, then push (5,5) and (−1,7) with 3-cycle gaps → busy stays high; result=prior+25−7, computed correctly with no spurious pops; start pulses during busy are ignored.
- Reset mid-FEED: drop reset for one edge during FEED → busy=0, in_ready=1, result_valid never pulses; next run of (2,3) with len=1 → result=6.
- Overflow (macro on): 2 pairs of (−128,−128) → result=−32768, result_ovf=1; then (100,100) len=1 → result=10000, result_ovf=0.
